boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 20 ++
 rtl/boot_loader.sv | 146 ++++++++++++++
 tb/tb_boot_loader.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the serial boot loader: state encoding and frame sync byte.
// Optional checksum stage is enabled by the BOOT_LOADER_CHECKSUM_EN macro in boot_loader.sv.
package boot_loader_pkg;

    localparam int STATE_W = 3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [STATE_W-1:0] {
        S_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses a sync/length/data frame and writes 16-bit words into RAM.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
)
(
    input  logic              clock_50_b7a,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t FRAME_END = S_CHECK;
`else
    localparam state_t FRAME_END = S_DONE;
`endif

    state_t            state;
    state_t            next_state;
    logic [7:0]        len_lo;
    logic [15:0]       word_count;
    logic [7:0]        low_byte;
    logic [ADDR_W:0]   word_idx;
    logic              accept;
    logic [15:0]       len_in;
    logic              len_too_big;
    logic              last_word;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        xor_acc;
`endif

    assign accept      = in_valid && in_ready;
    assign len_in      = {in_data, len_lo};
    // The index counter has one spare bit so a full 2^ADDR_W image can finish without wrapping.
    assign len_too_big = 32'(len_in) > (32'd1 << ADDR_W);
    assign last_word   = (32'(word_idx) + 32'd1) == 32'(word_count);

    always_ff @(posedge clock_50_b7a) begin
        if (!reset) begin
            state <= S_SYNC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                S_SYNC: begin
                    if (in_data == SYNC_BYTE) begin
                        next_state = S_LEN_LO;
                    end
                end
                S_LEN_LO:  next_state = S_LEN_HI;
                S_LEN_HI: begin
                    if (len_too_big) begin
                        next_state = S_ERR;
                    end else if (len_in == 16'd0) begin
                        next_state = FRAME_END;
                    end else begin
                        next_state = S_DATA_LO;
                    end
                end
                S_DATA_LO: next_state = S_DATA_HI;
                S_DATA_HI: next_state = last_word ? FRAME_END : S_DATA_LO;
`ifdef BOOT_LOADER_CHECKSUM_EN
                S_CHECK:   next_state = (in_data == xor_acc) ? S_DONE : S_ERR;
`else
                S_CHECK:   next_state = S_ERR;
`endif
                default:   next_state = state;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_DONE: begin
                in_ready = 1'b0;
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERR: begin
                in_ready = 1'b0;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobe is registered off the high-byte handshake, so it lands one cycle after acceptance.
    always_ff @(posedge clock_50_b7a) begin
        if (!reset) begin
            len_lo     <= '0;
            word_count <= '0;
            low_byte   <= '0;
            word_idx   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN_LO:  len_lo     <= in_data;
                    S_LEN_HI:  word_count <= len_in;
                    S_DATA_LO: low_byte   <= in_data;
                    S_DATA_HI: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx[ADDR_W-1:0];
                        mem_wdata <= DATA_W'({in_data, low_byte});
                        word_idx  <= word_idx + (ADDR_W+1)'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clock_50_b7a) begin
        if (!reset) begin
            xor_acc <= '0;
        end else if (accept && (state == S_DATA_LO || state == S_DATA_HI)) begin
            xor_acc <= xor_acc ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: vector table, hand sequences and randomized frames vs. a frame parser model.
// Follows the BOOT_LOADER_CHECKSUM_EN setting of the design build.
module tb_boot_loader;

    localparam int ADDR_W  = 8;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clock_50_b7a (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    logic [15:0] ram [0:(1<<ADDR_W)-1];
    logic        acc_edge = 1'b0;
    int          acc_count = 0;
    int          wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_at[$];

    always @(posedge clk) acc_edge = (in_valid === 1'b1) && (in_ready === 1'b1);

    // RAM model and write log; wr_at records how many bytes had been accepted when each write appeared.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            acc_count = 0;
            wr_addr.delete();
            wr_data.delete();
            wr_at.delete();
        end else begin
            if (acc_edge) acc_count++;
            if (mem_we === 1'b1) begin
                ram[mem_addr] = mem_wdata;
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(mem_wdata);
                wr_at.push_back(acc_count);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // gap: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idle cycles
    task automatic applyStimulus(input logic [7:0] s[$], input int gap);
        foreach (s[k]) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reference model: parses a byte stream by the frame rules and yields the words and final status.
    logic [15:0] exp_words[$];
    int          exp_status;

    function automatic void runModel(input logic [7:0] s[$]);
        int i = 0;
        int n;
`ifdef BOOT_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
`endif
        exp_words.delete();
        exp_status = ST_BUSY;
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 2 >= s.size()) return;
        n = 32'({s[i+2], s[i+1]});
        i += 3;
        if (n > (1 << ADDR_W)) begin
            exp_status = ST_ERR;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (i + 1 >= s.size()) return;
            exp_words.push_back({s[i+1], s[i]});
`ifdef BOOT_LOADER_CHECKSUM_EN
            x = x ^ s[i] ^ s[i+1];
`endif
            i += 2;
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (i >= s.size()) return;
        exp_status = (s[i] == x) ? ST_DONE : ST_ERR;
`else
        exp_status = ST_DONE;
`endif
    endfunction

    task automatic checkFrame(input string tag);
        checkOutput({tag, ".done"}, 32'(done), 32'(exp_status == ST_DONE));
        checkOutput({tag, ".error"}, 32'(error), 32'(exp_status == ST_ERR));
        checkOutput({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(exp_status != ST_DONE));
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(exp_status == ST_BUSY));
        checkOutput({tag, ".nwrites"}, 32'(wr_data.size()), 32'(exp_words.size()));
        foreach (exp_words[k]) begin
            if (k < wr_data.size()) begin
                checkOutput($sformatf("%s.addr%0d", tag, k), 32'(wr_addr[k]), 32'(k));
                checkOutput($sformatf("%s.data%0d", tag, k), 32'(wr_data[k]), 32'(exp_words[k]));
            end
        end
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b [16];
        logic        exp_done;
        logic        exp_error;
        logic        exp_ready;
        int          exp_nw;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string nm, input logic [7:0] s[$], input logic d, input logic e,
                          input logic r, input int nw, input logic [15:0] w0, input logic [15:0] w1);
        vec_t v;
        v.name = nm;
        v.n    = s.size();
        foreach (s[k]) v.b[k] = s[k];
        v.exp_done  = d;
        v.exp_error = e;
        v.exp_ready = r;
        v.exp_nw    = nw;
        v.exp_w0    = w0;
        v.exp_w1    = w1;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] s[$];

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        q = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h08);
`endif
        addVec("basic", q, 1'b1, 1'b0, 1'b0, 2, 16'h1234, 16'h5678);
        q = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h08);
`endif
        addVec("leading", q, 1'b1, 1'b0, 1'b0, 2, 16'h1234, 16'h5678);
        q = {8'hA5, 8'h01, 8'h01, 8'h34, 8'h12};
        addVec("oversize", q, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000);
        q = {8'hA5, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        addVec("zero_len", q, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 16'h0000);
        q = {8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h66);
`endif
        addVec("single", q, 1'b1, 1'b0, 1'b0, 1, 16'hABCD, 16'h0000);
        q = {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        addVec("sync_in_data", q, 1'b1, 1'b0, 1'b0, 1, 16'hA5A5, 16'h0000);
        q = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
        addVec("partial", q, 1'b0, 1'b0, 1'b1, 1, 16'h1234, 16'h0000);
`ifdef BOOT_LOADER_CHECKSUM_EN
        q = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
        addVec("bad_checksum", q, 1'b0, 1'b1, 1'b0, 2, 16'h1234, 16'h5678);
        q = {8'hA5, 8'h00, 8'h00, 8'h01};
        addVec("zero_len_bad", q, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000);
`endif

        doReset();
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset.mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset.mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("reset.cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.error", 32'(error), 32'd0);

        foreach (vecs[v]) begin
            s.delete();
            for (int k = 0; k < vecs[v].n; k++) s.push_back(vecs[v].b[k]);
            doReset();
            applyStimulus(s, 0);
            checkOutput({vecs[v].name, ".done"}, 32'(done), 32'(vecs[v].exp_done));
            checkOutput({vecs[v].name, ".error"}, 32'(error), 32'(vecs[v].exp_error));
            checkOutput({vecs[v].name, ".cpu_hold"}, 32'(cpu_hold), 32'(!vecs[v].exp_done));
            checkOutput({vecs[v].name, ".in_ready"}, 32'(in_ready), 32'(vecs[v].exp_ready));
            checkOutput({vecs[v].name, ".nwrites"}, 32'(wr_data.size()), 32'(vecs[v].exp_nw));
            if (vecs[v].exp_nw > 0 && wr_data.size() > 0) begin
                checkOutput({vecs[v].name, ".addr0"}, 32'(wr_addr[0]), 32'd0);
                checkOutput({vecs[v].name, ".data0"}, 32'(wr_data[0]), 32'(vecs[v].exp_w0));
            end
            if (vecs[v].exp_nw > 1 && wr_data.size() > 1) begin
                checkOutput({vecs[v].name, ".addr1"}, 32'(wr_addr[1]), 32'd1);
                checkOutput({vecs[v].name, ".data1"}, 32'(wr_data[1]), 32'(vecs[v].exp_w1));
            end
        end

        // Throttled source: writes must follow the 5th and 7th accepted bytes only.
        doReset();
        q = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h08);
`endif
        applyStimulus(q, 1);
        checkOutput("throttle.done", 32'(done), 32'd1);
        checkOutput("throttle.nwrites", 32'(wr_at.size()), 32'd2);
        if (wr_at.size() == 2) begin
            checkOutput("throttle.write0_after", 32'(wr_at[0]), 32'd5);
            checkOutput("throttle.write1_after", 32'(wr_at[1]), 32'd7);
        end
        checkOutput("throttle.ram0", 32'(ram[0]), 32'h1234);
        checkOutput("throttle.ram1", 32'(ram[1]), 32'h5678);

        // Reset in the middle of a frame, then a fresh frame.
        doReset();
        q = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12};
        applyStimulus(q, 0);
        checkOutput("midframe.in_ready", 32'(in_ready), 32'd1);
        checkOutput("midframe.done", 32'(done), 32'd0);
        checkOutput("midframe.nwrites", 32'(wr_data.size()), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset.mem_we", 32'(mem_we), 32'd0);
        checkOutput("midreset.mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midreset.mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("midreset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset.cpu_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("midreset.nowrite", 32'(wr_data.size()), 32'd0);
        checkOutput("midreset.ram0_kept", 32'(ram[0]), 32'h1234);
        q = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE};
`ifdef BOOT_LOADER_CHECKSUM_EN
        q.push_back(8'h51);
`endif
        applyStimulus(q, 0);
        checkOutput("fresh.done", 32'(done), 32'd1);
        checkOutput("fresh.nwrites", 32'(wr_data.size()), 32'd1);
        checkOutput("fresh.ram0", 32'(ram[0]), 32'hBEEF);

        // Randomized frames: junk prefix, random length (incl. 256 and oversize), random gaps and checksums.
        for (int it = 0; it < 8; it++) begin
            int n;
            logic [7:0] b;
            logic [7:0] x;
            s.delete();
            x = 8'h00;
            repeat ($urandom_range(0, 3)) begin
                do b = 8'($urandom); while (b == 8'hA5);
                s.push_back(b);
            end
            n = (it == 0) ? 256 : (it == 1) ? 257 + int'($urandom_range(0, 100)) : int'($urandom_range(0, 6));
            s.push_back(8'hA5);
            s.push_back(n[7:0]);
            s.push_back(n[15:8]);
            if (n <= 256) begin
                for (int w = 0; w < 2 * n; w++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    s.push_back(b);
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                s.push_back(x);
`endif
            end
            runModel(s);
            doReset();
            applyStimulus(s, 2);
            checkFrame($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
